// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network training blocks.
//  - nn_state_e   : sequencing states of the weight-update engine
//  - W_W/H_W/F_W  : default weight, hidden-activation and final/target widths
//  - SAT_GUARD_W  : extra bits kept above the wider operand of a saturating subtract
//  - idx_width()  : index width for an N-entry table (at least one bit)
//  - max_w()      : larger of two widths
package nn_pkg;

  localparam int W_W_DEF     = 8;
  localparam int H_W_DEF     = 10;
  localparam int F_W_DEF     = 19;
  localparam int SAT_GUARD_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    UPD,
    DONE
  } nn_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nn_sat_sub.sv
// Saturating signed subtract: y_o = clamp(a_i - b_i) into O_W-bit two's complement.
// Ports:
//  a_i   in  A_W  signed minuend
//  b_i   in  B_W  signed subtrahend
//  y_o   out O_W  clamped difference
//  sat_o out 1    high when the exact difference fell outside the O_W range
module nn_sat_sub
  import nn_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 32,
  parameter int O_W = 8
) (
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [O_W-1:0] y_o,
  output logic                  sat_o
);

  // The difference is evaluated exactly, one guard bit above the wider operand.
  localparam int D_W = max_w(A_W, B_W) + SAT_GUARD_W;

  localparam logic signed [D_W-1:0] MAX_V = {{(D_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
  localparam logic signed [D_W-1:0] MIN_V = {{(D_W-O_W+1){1'b1}}, {(O_W-1){1'b0}}};

  logic signed [D_W-1:0] a_ext;
  logic signed [D_W-1:0] b_ext;
  logic signed [D_W-1:0] diff;

  assign a_ext = {{(D_W-A_W){a_i[A_W-1]}}, a_i};
  assign b_ext = {{(D_W-B_W){b_i[B_W-1]}}, b_i};
  assign diff  = a_ext - b_ext;

  // NOTE: every output gets a default before the if/else so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    y_o   = diff[O_W-1:0];
    sat_o = 1'b0;
    if (diff > MAX_V) begin
      y_o   = MAX_V[O_W-1:0];
      sat_o = 1'b1;
    end else if (diff < MIN_V) begin
      y_o   = MIN_V[O_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/hidden_backprop_seq.sv
// Sequential hidden-layer weight-update engine.
// One training step: delta = (2*(target-final)*hidden) >>> LR_SHIFT is computed
// once, then each masked weight is replaced by sat(w - delta), one lane per cycle.
// Ports:
//  clk_i               clock
//  rst                 synchronous, active-low reset
//  start_i             request a step (accepted in IDLE only)
//  mask_i              per-lane update enable for the step
//  target_i / final_i  training target / network output (unsigned F_W)
//  hidden_val_i        hidden activation (unsigned H_W)
//  zero_weight_reset_i clear all weights and abort the step
//  w_wr_en_i/idx/data  host weight write, honoured in IDLE only
//  w_o                 packed weights, lane i = w_o[i*W_W +: W_W]
//  busy_o              high from accept through the done_o cycle
//  done_o              one-cycle completion pulse
//  sat_o               sticky saturation flag for the current/last step
module hidden_backprop_seq
  import nn_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int W_W      = W_W_DEF,
  parameter int H_W      = H_W_DEF,
  parameter int F_W      = F_W_DEF,
  parameter int LR_SHIFT = 8,
  localparam int IDX_W   = idx_width(N_IN)
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                start_i,
  input  logic [N_IN-1:0]     mask_i,
  input  logic [F_W-1:0]      target_i,
  input  logic [F_W-1:0]      final_i,
  input  logic [H_W-1:0]      hidden_val_i,
  input  logic                zero_weight_reset_i,
  input  logic                w_wr_en_i,
  input  logic [IDX_W-1:0]    w_wr_idx_i,
  input  logic [W_W-1:0]      w_wr_data_i,
  output logic [N_IN*W_W-1:0] w_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                sat_o
);

  localparam int G_W = F_W + 2;        // 2*(target-final)
  localparam int P_W = F_W + H_W + 3;  // grad * hidden

  nn_state_e state_q, state_d;

  logic [N_IN-1:0]       mask_q;
  logic [F_W-1:0]        target_q;
  logic [F_W-1:0]        final_q;
  logic [H_W-1:0]        hidden_q;
  logic signed [P_W-1:0] delta_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  sat_q;
  logic signed [W_W-1:0] w_q [N_IN];

  logic accept;
  logic load_delta;
  logic upd_en;
  logic host_wr;

  // ---------------------------------------------------------------- datapath
  logic [G_W-1:0]        diff_u;
  logic signed [G_W-1:0] grad;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] delta;
  logic signed [W_W-1:0] sub_y;
  logic                  sub_sat;

  // Zero-extended subtraction wraps to the correct two's-complement value.
  assign diff_u = {2'b00, target_q} - {2'b00, final_q};
  assign grad   = $signed({diff_u[G_W-2:0], 1'b0});
  assign prod   = $signed({{(H_W+1){grad[G_W-1]}}, grad})
                * $signed({{(F_W+2){1'b0}}, hidden_q});
  assign delta  = prod >>> LR_SHIFT;

  nn_sat_sub #(
    .A_W (W_W),
    .B_W (P_W),
    .O_W (W_W)
  ) u_sat_sub (
    .a_i   (w_q[idx_q]),
    .b_i   (delta_q),
    .y_o   (sub_y),
    .sat_o (sub_sat)
  );

  // Host writes only land in IDLE; out-of-range indices are dropped.
  assign host_wr = w_wr_en_i && (state_q == IDLE) && (int'(w_wr_idx_i) < N_IN);

  // -------------------------------------------------------------------- FSM
  // NOTE: state and data registers use non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (zero_weight_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_delta = 1'b0;
    upd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        // A host write in the same cycle has priority over a start request.
        if (start_i && !host_wr) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        load_delta = 1'b1;
        state_d    = UPD;
      end
      UPD: begin
        upd_en = 1'b1;
        if (idx_q == IDX_W'(N_IN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------- registers
  // NOTE: the weight table is reset explicitly because cleared weights on
  // reset are part of the block's visible behaviour, not just a convenience.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      mask_q   <= '0;
      target_q <= '0;
      final_q  <= '0;
      hidden_q <= '0;
      delta_q  <= '0;
      idx_q    <= '0;
      sat_q    <= 1'b0;
    end else if (zero_weight_reset_i) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      idx_q <= '0;
      sat_q <= 1'b0;
    end else if (host_wr) begin
      w_q[w_wr_idx_i] <= $signed(w_wr_data_i);
    end else begin
      if (accept) begin
        mask_q   <= mask_i;
        target_q <= target_i;
        final_q  <= final_i;
        hidden_q <= hidden_val_i;
        sat_q    <= 1'b0;
      end
      if (load_delta) begin
        delta_q <= delta;
        idx_q   <= '0;
      end
      if (upd_en) begin
        if (mask_q[idx_q]) begin
          w_q[idx_q] <= sub_y;
          if (sub_sat) sat_q <= 1'b1;
        end
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // ----------------------------------------------------------------- outputs
  for (genvar g = 0; g < N_IN; g++) begin : g_w_out
    assign w_o[g*W_W +: W_W] = w_q[g];
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_hidden_backprop_seq.sv
// Self-checking bench for hidden_backprop_seq (N_IN=4, W_W=8, H_W=10, F_W=19, LR_SHIFT=4).
// Stimulus pushes the model's expected end-of-step weights/sat/done cycle into a
// queue; a monitor pops and compares on every done_o pulse.
module tb_hidden_backprop_seq;

  localparam int N_IN     = 4;
  localparam int W_W      = 8;
  localparam int H_W      = 10;
  localparam int F_W      = 19;
  localparam int LR_SHIFT = 4;

  logic                clk_i = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic [N_IN-1:0]     mask_i = '0;
  logic [F_W-1:0]      target_i = '0;
  logic [F_W-1:0]      final_i = '0;
  logic [H_W-1:0]      hidden_val_i = '0;
  logic                zero_weight_reset_i = 1'b0;
  logic                w_wr_en_i = 1'b0;
  logic [1:0]          w_wr_idx_i = '0;
  logic [W_W-1:0]      w_wr_data_i = '0;
  logic [N_IN*W_W-1:0] w_o;
  logic                busy_o;
  logic                done_o;
  logic                sat_o;

  hidden_backprop_seq #(
    .N_IN(N_IN), .W_W(W_W), .H_W(H_W), .F_W(F_W), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk_i               (clk_i),
    .rst                 (rst),
    .start_i             (start_i),
    .mask_i              (mask_i),
    .target_i            (target_i),
    .final_i             (final_i),
    .hidden_val_i        (hidden_val_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .w_wr_en_i           (w_wr_en_i),
    .w_wr_idx_i          (w_wr_idx_i),
    .w_wr_data_i         (w_wr_data_i),
    .w_o                 (w_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .sat_o               (sat_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [N_IN*W_W-1:0] w;
    logic                sat;
    int                  done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   mw[N_IN];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input logic [N_IN*W_W-1:0] v, input int i);
    logic signed [W_W-1:0] s;
    s = v[i*W_W +: W_W];
    return int'(s);
  endfunction

  // Floor division by 2^LR_SHIFT, written as ordinary integer arithmetic.
  function automatic longint floor_div(input longint p);
    longint d;
    d = longint'(1) << LR_SHIFT;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  // Reference: apply one training step to the model weights, queue the result.
  task automatic model_step(input logic [N_IN-1:0] m, input logic [F_W-1:0] t,
                            input logic [F_W-1:0] f, input logic [H_W-1:0] h,
                            input int acc_cyc);
    longint p, delta, v;
    exp_t   e;
    p     = 2 * (longint'(t) - longint'(f)) * longint'(h);
    delta = floor_div(p);
    e.sat = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (m[i]) begin
        v = longint'(mw[i]) - delta;
        if (v > 127) begin v = 127; e.sat = 1'b1; end
        else if (v < -128) begin v = -128; e.sat = 1'b1; end
        mw[i] = int'(v);
      end
    end
    for (int i = 0; i < N_IN; i++) e.w[i*W_W +: W_W] = W_W'(mw[i]);
    e.done_cyc = acc_cyc + N_IN + 2;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every done_o pulse against the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst && done_o) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        for (int i = 0; i < N_IN; i++)
          check($sformatf("sb_w%0d", i), lane(w_o, i), lane(e.w, i));
        check("sb_sat", sat_o, e.sat);
        check("sb_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 64) begin @(posedge clk_i); #1; k++; end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb_q.size() != 0 && k < 64) begin @(posedge clk_i); #1; k++; end
    if (sb_q.size() != 0) check("done_timeout", sb_q.size(), 0);
  endtask

  task automatic step(input logic [N_IN-1:0] m, input logic [F_W-1:0] t,
                      input logic [F_W-1:0] f, input logic [H_W-1:0] h);
    wait_idle();
    mask_i = m; target_i = t; final_i = f; hidden_val_i = h; start_i = 1'b1;
    model_step(m, t, f, h, cyc);
    @(posedge clk_i); #1;
    start_i      = 1'b0;
    mask_i       = N_IN'($urandom);
    target_i     = F_W'($urandom);
    final_i      = F_W'($urandom);
    hidden_val_i = H_W'($urandom);
  endtask

  task automatic host_write(input int idx, input int val);
    w_wr_en_i = 1'b1; w_wr_idx_i = 2'(idx); w_wr_data_i = W_W'(val);
    mw[idx] = lane({(N_IN*W_W)'(w_wr_data_i)}, 0);
    @(posedge clk_i); #1;
    w_wr_en_i = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
  endtask

  initial begin
    int saved_done;
    logic [F_W-1:0] t, f;
    clear_model();

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b1;
    check("rst_w", w_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sat", sat_o, 0);

    // Basic: delta = 2*2*8 >>> 4 = 2
    for (int i = 0; i < N_IN; i++) host_write(i, 10);
    step(4'b0101, 3, 1, 8);
    wait_done();
    check("basic_w0", lane(w_o, 0), 8);
    check("basic_w1", lane(w_o, 1), 10);
    check("basic_w2", lane(w_o, 2), 8);
    check("basic_w3", lane(w_o, 3), 10);
    check("basic_sat", sat_o, 0);

    // Positive saturation: delta = -200
    host_write(0, 100);
    step(4'b0001, 0, 100, 16);
    wait_done();
    check("satp_w0", lane(w_o, 0), 127);
    check("satp_flag", sat_o, 1);

    // Negative saturation: delta = +100
    host_write(0, -100);
    step(4'b0001, 100, 0, 8);
    wait_done();
    check("satn_w0", lane(w_o, 0), -128);
    check("satn_flag", sat_o, 1);

    // Floor of a negative product: prod = -2 -> delta = -1
    host_write(0, 5);
    step(4'b0001, 0, 1, 1);
    wait_done();
    check("floor_w0", lane(w_o, 0), 6);
    check("floor_sat_cleared", sat_o, 0);

    // Empty mask: full sequence, weights unchanged
    step(4'b0000, 500, 3, 700);
    wait_done();

    // start_i and host write while busy are ignored
    step(4'b1111, 10, 2, 3);
    start_i = 1'b1; mask_i = 4'b1111; target_i = 0; final_i = 9000; hidden_val_i = 1000;
    w_wr_en_i = 1'b1; w_wr_idx_i = 2'd1; w_wr_data_i = 8'd55;
    repeat (2) begin @(posedge clk_i); #1; end
    start_i = 1'b0; w_wr_en_i = 1'b0;
    saved_done = n_done;
    wait_done();
    repeat (10) begin @(posedge clk_i); #1; end
    check("busy_ignore_one_done", n_done - saved_done, 1);

    // Abort at cycle 3 of a step
    step(4'b1111, 7, 0, 40);
    repeat (2) begin @(posedge clk_i); #1; end
    zero_weight_reset_i = 1'b1;
    clear_model();
    saved_done = n_done;
    @(posedge clk_i); #1;
    zero_weight_reset_i = 1'b0;
    check("abort_w", w_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_sat", sat_o, 0);
    repeat (10) begin @(posedge clk_i); #1; end
    check("abort_no_done", n_done, saved_done);
    step(4'b0110, 0, 9, 20);
    wait_done();

    // Randomised steps, back-to-back, with occasional host writes in between
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        host_write(int'($urandom_range(0, N_IN - 1)), int'($urandom_range(0, 255)) - 128);
      end
      t = F_W'($urandom);
      if ($urandom_range(0, 1) == 0) f = F_W'($urandom);
      else f = t + F_W'($urandom_range(0, 40)) - F_W'(20);
      step(N_IN'($urandom), t, f, H_W'($urandom_range(0, (n % 2 == 0) ? 63 : 1023)));
    end
    wait_done();

    // Reset in the middle of a step
    step(4'b1111, 1000, 0, 500);
    @(posedge clk_i); #1;
    rst = 1'b0;
    clear_model();
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_w", w_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_sat", sat_o, 0);
    @(posedge clk_i); #1;
    rst = 1'b1;
    step(4'b1000, 3, 0, 16);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
